// File: rtl/urv_pipe_pkg.sv
// Shared constants for the uRV pipeline controller: stage indices of the default
// 5-stage pipe, perf counter width, stage-count limits and the watchdog width helper.
package urv_pipe_pkg;

  localparam int unsigned URV_MIN_STAGES = 3;
  localparam int unsigned URV_MAX_STAGES = 8;
  localparam int unsigned URV_PERF_CNT_W = 32;

  localparam int unsigned URV_STAGE_F = 0;
  localparam int unsigned URV_STAGE_D = 1;
  localparam int unsigned URV_STAGE_X = 2;
  localparam int unsigned URV_STAGE_W = 4;

  // Width that holds 0..limit; never narrower than one bit.
  function automatic int unsigned wd_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/urv_kill_shreg.sv
// Kill delay line: shifts d_i in while shift_en_i is high; tap_or_o[k] is
// d_i OR any of the first k+1 delayed copies.
module urv_kill_shreg #(
  parameter int unsigned depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             shift_en_i,
  input  logic             d_i,
  output logic [depth-1:0] tap_or_o
);

  logic [depth-1:0] sr_q;
  logic [depth-1:0] sr_d;
  logic             tap_acc;

  always_comb begin
    sr_d = sr_q;
    if (shift_en_i) begin
      sr_d[0] = d_i;
      for (int i = 1; i < int'(depth); i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  // NOTE: non-blocking assignment here so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // NOTE: every variable gets a default before the loop so no path infers a latch.
  always_comb begin
    tap_or_o = '0;
    tap_acc  = d_i;
    for (int i = 0; i < int'(depth); i++) begin
      tap_acc     = tap_acc | sr_q[i];
      tap_or_o[i] = tap_acc;
    end
  end

endmodule

// File: rtl/urv_pipe_ctrl.sv
// uRV pipeline stall/kill controller with stall watchdog. Optional performance
// counters are built only when URV_PIPE_CTRL_PERF_EN is defined.
module urv_pipe_ctrl
  import urv_pipe_pkg::*;
#(
  parameter int unsigned g_num_stages = URV_STAGE_W + 1,
  parameter int unsigned g_bra_stage  = URV_STAGE_X,
  parameter int unsigned g_timeout    = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [g_num_stages-1:0]   stall_req_i,
  input  logic                      bra_i,
  input  logic                      flush_i,
  input  logic                      perf_clr_i,
  output logic [g_num_stages-1:0]   stall_o,
  output logic [g_num_stages-1:0]   kill_o,
  output logic                      timeout_o,
  output logic [URV_PERF_CNT_W-1:0] perf_stall_cnt_o,
  output logic [URV_PERF_CNT_W-1:0] perf_kill_cnt_o
);

  localparam int N = int'(g_num_stages);
  localparam int B = int'(g_bra_stage);

  logic         stall_acc;
  logic [B-1:0] bra_taps;
  logic [N-2:0] fl_taps;
  logic [N-1:0] bra_kill;
  logic [N-1:0] fl_kill;

  // A stage stalls whenever it or anything downstream asks to.
  always_comb begin
    stall_o   = '0;
    stall_acc = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      stall_acc  = stall_acc | stall_req_i[k];
      stall_o[k] = stall_acc;
    end
  end

  urv_kill_shreg #(.depth(g_bra_stage)) u_bra_shreg (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .shift_en_i (~stall_o[B]),
    .d_i        (bra_i),
    .tap_or_o   (bra_taps)
  );

  urv_kill_shreg #(.depth(g_num_stages - 1)) u_fl_shreg (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .shift_en_i (~stall_o[N-1]),
    .d_i        (flush_i),
    .tap_or_o   (fl_taps)
  );

  // Fetch is redirected rather than killed, so bit 0 never gets a contribution.
  always_comb begin
    bra_kill        = '0;
    fl_kill         = '0;
    bra_kill[B:1]   = bra_taps;
    fl_kill[N-1:1]  = fl_taps;
    kill_o          = bra_kill | fl_kill;
    kill_o[URV_STAGE_F] = 1'b0;
  end

  generate
    if (g_timeout == 0) begin : g_no_wd
      assign timeout_o = 1'b0;
    end else begin : g_wd
      localparam int unsigned WD_W = wd_width(g_timeout);
      localparam logic [WD_W-1:0] WD_MAX = WD_W'(g_timeout);

      logic [WD_W-1:0] wd_q, wd_d;
      logic            to_q, to_d;

      // Saturating run-length of fetch stalls; the pulse fires on the step into WD_MAX.
      always_comb begin
        wd_d = wd_q;
        if (!stall_o[0]) begin
          wd_d = '0;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
        to_d = stall_o[0] && (wd_q == WD_MAX - 1'b1);
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          wd_q <= '0;
          to_q <= 1'b0;
        end else begin
          wd_q <= wd_d;
          to_q <= to_d;
        end
      end

      assign timeout_o = to_q;
    end
  endgenerate

`ifdef URV_PIPE_CTRL_PERF_EN
  logic [URV_PERF_CNT_W-1:0] perf_stall_q;
  logic [URV_PERF_CNT_W-1:0] perf_kill_q;

  // Clear has priority over counting; both counters wrap naturally.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_stall_q <= '0;
      perf_kill_q  <= '0;
    end else if (perf_clr_i) begin
      perf_stall_q <= '0;
      perf_kill_q  <= '0;
    end else begin
      if (stall_o[0]) perf_stall_q <= perf_stall_q + 32'd1;
      if (|kill_o)    perf_kill_q  <= perf_kill_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_kill_cnt_o  = perf_kill_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr  = perf_clr_i;
  assign perf_stall_cnt_o = '0;
  assign perf_kill_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Self-checking bench for urv_pipe_ctrl: directed vector table, hand-written
// watchdog/perf/reset sequences and randomized traffic against an event-age model.
module tb_urv_pipe_ctrl;

  localparam int N = 5;
  localparam int B = 2;
  localparam int T = 8;
`ifdef URV_PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] stall_req_i;
  logic         bra_i;
  logic         flush_i;
  logic         perf_clr_i;
  logic [N-1:0] stall_o;
  logic [N-1:0] kill_o;
  logic         timeout_o;
  logic [31:0]  perf_stall_cnt_o;
  logic [31:0]  perf_kill_cnt_o;

  always #5 clk = ~clk;

  urv_pipe_ctrl #(
    .g_num_stages (N),
    .g_bra_stage  (B),
    .g_timeout    (T)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .stall_req_i      (stall_req_i),
    .bra_i            (bra_i),
    .flush_i          (flush_i),
    .perf_clr_i       (perf_clr_i),
    .stall_o          (stall_o),
    .kill_o           (kill_o),
    .timeout_o        (timeout_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_kill_cnt_o  (perf_kill_cnt_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Reference model: each recorded branch/flush is an event with an age (cycles
  // it has advanced); a stage s is killed by events younger than s.
  int          bra_age[$];
  int          fl_age[$];
  int          run;
  logic [31:0] m_ps, m_pk;

  logic        last_to;
  logic [31:0] last_ps;

  task automatic model_reset();
    bra_age.delete();
    fl_age.delete();
    run  = 0;
    m_ps = '0;
    m_pk = '0;
  endtask

  function automatic logic [N-1:0] model_stall(input logic [N-1:0] req);
    logic [N-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s[k] = ((req >> k) != 0);
    return s;
  endfunction

  function automatic logic [N-1:0] model_kill(input logic bra, input logic fl);
    logic [N-1:0] k;
    k = '0;
    for (int s = 1; s < N; s++) begin
      if (fl) k[s] = 1'b1;
      foreach (fl_age[i]) if (fl_age[i] < s) k[s] = 1'b1;
      if (s <= B) begin
        if (bra) k[s] = 1'b1;
        foreach (bra_age[i]) if (bra_age[i] < s) k[s] = 1'b1;
      end
    end
    return k;
  endfunction

  task automatic model_update(input logic [N-1:0] req, input logic bra, input logic fl,
                              input logic clr, input logic [N-1:0] kill_exp);
    int tmp[$];
    if ((req >> B) == 0) begin
      tmp = {};
      foreach (bra_age[i]) if (bra_age[i] + 1 < B) tmp.push_back(bra_age[i] + 1);
      if (bra) tmp.push_back(0);
      bra_age = tmp;
    end
    if ((req >> (N - 1)) == 0) begin
      tmp = {};
      foreach (fl_age[i]) if (fl_age[i] + 1 < N - 1) tmp.push_back(fl_age[i] + 1);
      if (fl) tmp.push_back(0);
      fl_age = tmp;
    end
    run = (req != 0) ? run + 1 : 0;
    if (clr) begin
      m_ps = '0;
      m_pk = '0;
    end else begin
      if (req != 0)      m_ps = m_ps + 32'd1;
      if (kill_exp != 0) m_pk = m_pk + 32'd1;
    end
  endtask

  // One clock cycle: entered just after a rising edge, returns just after the next.
  task automatic cycle(input logic [N-1:0] req, input logic bra, input logic fl, input logic clr,
                       input bit tab, input logic [N-1:0] t_kill, input logic [N-1:0] t_stall,
                       input string tag);
    logic [N-1:0] ek;
    stall_req_i = req;
    bra_i       = bra;
    flush_i     = fl;
    perf_clr_i  = clr;
    @(negedge clk);
    ek = model_kill(bra, fl);
    check({tag, "_stall"},   32'(stall_o),   32'(model_stall(req)));
    check({tag, "_kill"},    32'(kill_o),    32'(ek));
    check({tag, "_timeout"}, 32'(timeout_o), 32'(run == T));
    check({tag, "_pstall"},  perf_stall_cnt_o, PERF ? m_ps : 32'd0);
    check({tag, "_pkill"},   perf_kill_cnt_o,  PERF ? m_pk : 32'd0);
    if (tab) begin
      check({tag, "_tab_kill"},  32'(kill_o),  32'(t_kill));
      check({tag, "_tab_stall"}, 32'(stall_o), 32'(t_stall));
    end
    last_to = timeout_o;
    last_ps = perf_stall_cnt_o;
    model_update(req, bra, fl, clr, ek);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         bra;
    logic         fl;
    logic [N-1:0] kill;
    logic [N-1:0] stall;
  } vec_t;

  vec_t tab[$];

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int           cnt;
    int           first;
    logic [N-1:0] req;
    logic         bra, fl, clr;
    logic         prev_bra, prev_fl, prev_bstall;
    int           burst;

    // Branch, no stalls.
    tab.push_back('{5'b00000, 1'b1, 1'b0, 5'b00110, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b00110, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b00100, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00000});
    // Branch held while stage 3 stalls for 4 cycles.
    for (int i = 0; i < 4; i++) tab.push_back('{5'b01000, 1'b1, 1'b0, 5'b00110, 5'b01111});
    tab.push_back('{5'b00000, 1'b1, 1'b0, 5'b00110, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b00110, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b00100, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00000});
    // Flush and branch together.
    tab.push_back('{5'b00000, 1'b1, 1'b1, 5'b11110, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b11110, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b11100, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b11000, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b10000, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00000});
    // Flush and branch together while only the branch line is frozen.
    tab.push_back('{5'b01000, 1'b1, 1'b1, 5'b11110, 5'b01111});
    tab.push_back('{5'b01000, 1'b1, 1'b0, 5'b11110, 5'b01111});
    tab.push_back('{5'b00000, 1'b1, 1'b0, 5'b11110, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b11110, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b10100, 5'b00000});
    tab.push_back('{5'b00000, 1'b0, 1'b0, 5'b00000, 5'b00000});

    rst_n       = 1'b1;
    stall_req_i = '0;
    bra_i       = 1'b0;
    flush_i     = 1'b0;
    perf_clr_i  = 1'b0;
    last_to     = 1'b0;
    last_ps     = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_kill",    32'(kill_o),    32'd0);
    check("reset_stall",   32'(stall_o),   32'd0);
    check("reset_timeout", 32'(timeout_o), 32'd0);
    check("reset_pstall",  perf_stall_cnt_o, 32'd0);
    check("reset_pkill",   perf_kill_cnt_o,  32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tab[i])
      cycle(tab[i].req, tab[i].bra, tab[i].fl, 1'b0, 1'b1, tab[i].kill, tab[i].stall,
            $sformatf("vec%0d", i));

    // Watchdog: one pulse 8 cycles into a long stall, another after a re-raise.
    cnt = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "wd_a");
      if (last_to) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("wd_a_pulses", 32'(cnt), 32'd1);
    check("wd_a_cycle",  32'(first), 32'd8);
    cycle(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "wd_drop");
    cnt = 0; first = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "wd_b");
      if (last_to) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("wd_b_pulses", 32'(cnt), 32'd1);
    check("wd_b_cycle",  32'(first), 32'd8);

    // Perf clear concurrent with a stall.
    cycle(5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, "pc_pre");
    for (int i = 0; i < 10; i++) cycle(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "pc_run");
    cycle(5'b00001, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, "pc_clr");
    check("perf_before_clr", last_ps, PERF ? 32'd10 : 32'd0);
    cycle(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "pc_post");
    check("perf_after_clr", last_ps, 32'd0);

    // Reset in the middle of a branch kill sequence.
    cycle(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, "rk_c0");
    stall_req_i = '0;
    bra_i       = 1'b0;
    @(negedge clk);
    check("rk_pre_kill", 32'(kill_o), 32'b00110);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rk_kill",    32'(kill_o),    32'd0);
    check("rk_timeout", 32'(timeout_o), 32'd0);
    check("rk_pstall",  perf_stall_cnt_o, 32'd0);
    check("rk_pkill",   perf_kill_cnt_o,  32'd0);
    bra_i       = 1'b1;
    stall_req_i = 5'b00100;
    #1;
    check("rk_bra_kill",  32'(kill_o),  32'b00110);
    check("rk_stall",     32'(stall_o), 32'b00111);
    flush_i = 1'b1;
    #1;
    check("rk_both_kill", 32'(kill_o),  32'b11110);
    bra_i       = 1'b0;
    flush_i     = 1'b0;
    stall_req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      cycle(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000, "rk_after");

    // Randomized traffic; the branch source holds bra_i while its stage is stalled.
    prev_bra = 1'b0; prev_fl = 1'b0; prev_bstall = 1'b0; burst = 0;
    for (int i = 0; i < 3000; i++) begin
      req = '0;
      for (int b = 0; b < N; b++) req[b] = ($urandom_range(0, 15) == 0);
      if (burst > 0) begin
        req[0] = 1'b1;
        burst--;
      end else if ($urandom_range(0, 63) == 0) begin
        burst = $urandom_range(6, 14);
      end
      bra = prev_bstall ? prev_bra : ($urandom_range(0, 3) == 0);
      fl  = prev_fl ? 1'b0 : ($urandom_range(0, 11) == 0);
      clr = ($urandom_range(0, 49) == 0);
      cycle(req, bra, fl, clr, 1'b0, '0, '0, "rnd");
      prev_bra    = bra;
      prev_fl     = fl;
      prev_bstall = ((req >> B) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
